// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx
// Memory-mapped 8N1 UART transmitter on the CPU data-memory bus.
// CPU stores to DATA_ADDR push data[7:0] into a byte FIFO. A serializer
// drains the FIFO onto uart_txd, LSB first. Frames are sent back-to-back
// while bytes are queued. Loads from STATUS_ADDR return transmitter/FIFO
// state. Stores to STATUS_ADDR with data[3] set clear the sticky overflow.
//
// Ports
//   clock         in   system clock, all state updates on posedge
//   reset         in   synchronous active-high reset
//   wren          in   CPU data-memory write enable
//   address_dmem  in   CPU data-memory address (full 32-bit compare)
//   data          in   CPU store data
//   q_io          out  read data (combinational)
//   sel           out  address hits DATA_ADDR or STATUS_ADDR (combinational)
//   uart_txd      out  serial line, registered, idle high
//   busy          out  FIFO not empty or serializer not idle
//
// Status word: [0] tx_active, [1] empty, [2] full, [3] overflow,
//              [15:8] FIFO count, all other bits 0.
// FIFO_DEPTH must be a power of two and at least 2; CLKS_PER_BIT >= 2.
module mmio_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter logic [31:0] DATA_ADDR    = 32'd4098,
  parameter logic [31:0] STATUS_ADDR  = 32'd4099
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wren,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  output logic [31:0] q_io,
  output logic        sel,
  output logic        uart_txd,
  output logic        busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          overflow_q, overflow_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    fifo_mem_q [FIFO_DEPTH];

  logic          is_data_s, is_status_s;
  logic          fifo_empty_s, fifo_full_s;
  logic          baud_done_s, pop_s;
  logic          push_req_s, push_ok_s, drop_s, clear_s;
  logic [7:0]    head_s, count_ext_s;
  logic [31:0]   status_s;
  logic          unused_s;

  assign is_data_s    = (address_dmem == DATA_ADDR);
  assign is_status_s  = (address_dmem == STATUS_ADDR);
  assign fifo_empty_s = (count_q == '0);
  assign fifo_full_s  = (count_q == CNT_FULL);
  assign baud_done_s  = (baud_q == BAUD_LAST);
  assign head_s       = fifo_mem_q[rd_ptr_q];

  // A pop happens when idle, or at the very end of STOP so the next start
  // bit follows the stop bit with no idle gap.
  assign pop_s = !fifo_empty_s &&
                 ((state_q == S_IDLE) || ((state_q == S_STOP) && baud_done_s));

  // A push into a full FIFO still succeeds when a pop frees a slot on the same edge.
  assign push_req_s = wren && is_data_s;
  assign push_ok_s  = push_req_s && (!fifo_full_s || pop_s);
  assign drop_s     = push_req_s && !push_ok_s;
  assign clear_s    = wren && is_status_s && data[3];

  assign count_ext_s = 8'(count_q);
  assign status_s    = {16'h0000, count_ext_s, 4'h0, overflow_q, fifo_full_s,
                        fifo_empty_s, (state_q != S_IDLE)};

  assign sel      = is_data_s || is_status_s;
  assign uart_txd = txd_q;
  assign busy     = !fifo_empty_s || (state_q != S_IDLE);
  assign unused_s = ^data[31:8];

  // Read mux: only the status address returns anything non-zero.
  always_comb begin
    q_io = 32'h0000_0000;
    if (is_status_s) begin
      q_io = status_s;
    end else begin
      q_io = 32'h0000_0000;
    end
  end

  // FIFO occupancy and sticky overflow next-state; a drop beats a clear.
  always_comb begin
    count_d = count_q;
    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    overflow_d = overflow_q;
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (clear_s) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Serializer next-state: the baud counter restarts on every state/bit change.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    txd_d     = txd_q;
    case (state_q)
      S_IDLE: begin
        if (pop_s) begin
          state_d = S_START;
          baud_d  = '0;
          shift_d = head_s;
          txd_d   = 1'b0;
        end else begin
          txd_d = 1'b1;
        end
      end
      S_START: begin
        if (baud_done_s) begin
          state_d   = S_DATA;
          baud_d    = '0;
          bit_idx_d = 3'd0;
          txd_d     = shift_q[0];
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      S_DATA: begin
        if (baud_done_s) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
            txd_d   = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            txd_d     = shift_q[bit_idx_q + 3'd1];
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      S_STOP: begin
        if (baud_done_s) begin
          baud_d = '0;
          if (pop_s) begin
            state_d = S_START;
            shift_d = head_s;
            txd_d   = 1'b0;
          end else begin
            state_d = S_IDLE;
            txd_d   = 1'b1;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        txd_d   = 1'b1;
      end
    endcase
  end

  // State registers: serializer, FIFO pointers/count and overflow flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
      txd_q      <= 1'b1;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      overflow_q <= overflow_d;
      count_q    <= count_d;
      if (push_ok_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

  // FIFO storage; contents are don't-care while the count says empty.
  always_ff @(posedge clock) begin
    if (push_ok_s && !reset) begin
      fifo_mem_q[wr_ptr_q] <= data[7:0];
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=16.
// A frame-level reference model (byte queue + position within a 10-bit frame)
// predicts uart_txd, busy and the status word after every clock edge.
module tb_mmio_uart_tx;

  localparam int          C      = 4;
  localparam int          DEPTH  = 16;
  localparam int          FRAME  = 10 * C;
  localparam logic [31:0] DADDR  = 32'd4098;
  localparam logic [31:0] SADDR  = 32'd4099;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wren = 1'b0;
  logic [31:0] address_dmem = 32'h0;
  logic [31:0] data = 32'h0;
  logic [31:0] q_io;
  logic        sel;
  logic        uart_txd;
  logic        busy;

  mmio_uart_tx #(
    .CLKS_PER_BIT(C),
    .FIFO_DEPTH  (DEPTH),
    .DATA_ADDR   (DADDR),
    .STATUS_ADDR (SADDR)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .wren        (wren),
    .address_dmem(address_dmem),
    .data        (data),
    .q_io        (q_io),
    .sel         (sel),
    .uart_txd    (uart_txd),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pending bytes, byte on the wire, position in its frame.
  logic [7:0] m_q[$];
  logic [7:0] m_cur = 8'h00;
  bit         m_act = 1'b0;
  int         m_t   = 0;
  bit         m_ovf = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at time %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic w, input logic [31:0] a, input logic [31:0] d, input logic r);
    int  sz;
    bit  pop, push, acc;
    if (r) begin
      m_q.delete();
      m_act = 1'b0;
      m_t   = 0;
      m_ovf = 1'b0;
      return;
    end
    sz   = m_q.size();
    pop  = (sz > 0) && (!m_act || (m_t == FRAME - 1));
    push = w && (a == DADDR);
    acc  = push && ((sz < DEPTH) || pop);
    if (pop) begin
      m_cur = m_q.pop_front();
      m_act = 1'b1;
      m_t   = 0;
    end else if (m_act) begin
      if (m_t == FRAME - 1) m_act = 1'b0;
      else m_t++;
    end
    if (acc) m_q.push_back(d[7:0]);
    if (push && !acc) m_ovf = 1'b1;
    else if (w && (a == SADDR) && d[3]) m_ovf = 1'b0;
  endtask

  function automatic logic exp_txd();
    if (!m_act) return 1'b1;
    if (m_t < C) return 1'b0;
    if (m_t < 9 * C) return m_cur[(m_t - C) / C];
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_status();
    logic [7:0] cnt;
    cnt = 8'(m_q.size());
    return {16'h0000, cnt, 4'h0, m_ovf, (m_q.size() == DEPTH), (m_q.size() == 0), m_act};
  endfunction

  // One clock: drive inputs, take the edge, check outputs and the status word.
  // Leaves wren=0 and the status address driven, so q_io shows status afterwards.
  task automatic step(input logic w, input logic [31:0] a, input logic [31:0] d, input logic r);
    wren = w; address_dmem = a; data = d; reset = r;
    @(posedge clock);
    model_edge(w, a, d, r);
    #1;
    check("txd", {31'h0, uart_txd}, {31'h0, exp_txd()});
    check("busy", {31'h0, busy}, {31'h0, (m_act || (m_q.size() != 0))});
    wren = 1'b0; address_dmem = SADDR; reset = 1'b0;
    #1;
    check("status", q_io, exp_status());
    check("sel_status", {31'h0, sel}, 32'h1);
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, SADDR, 32'h0, 1'b0);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp_q;
    logic        exp_sel;
  } vec_t;
  vec_t tbl[6];

  logic [7:0] a5_bits;
  int         guard;

  initial begin
    tbl[0] = '{addr: 32'd4097,       exp_q: 32'h0000_0000, exp_sel: 1'b0};
    tbl[1] = '{addr: DADDR,          exp_q: 32'h0000_0000, exp_sel: 1'b1};
    tbl[2] = '{addr: SADDR,          exp_q: 32'h0000_0002, exp_sel: 1'b1};
    tbl[3] = '{addr: 32'h0000_0000,  exp_q: 32'h0000_0000, exp_sel: 1'b0};
    tbl[4] = '{addr: 32'h8000_1003,  exp_q: 32'h0000_0000, exp_sel: 1'b0};
    tbl[5] = '{addr: 32'd4100,       exp_q: 32'h0000_0000, exp_sel: 1'b0};

    // 1. reset then idle
    @(negedge clock);
    step(1'b0, SADDR, 32'h0, 1'b1);
    step(1'b0, SADDR, 32'h0, 1'b1);
    idle(20);
    check("reset_txd", {31'h0, uart_txd}, 32'h1);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_status", q_io, 32'h0000_0002);
    for (int i = 0; i < 6; i++) begin
      address_dmem = tbl[i].addr;
      #1;
      check("decode_q", q_io, tbl[i].exp_q);
      check("decode_sel", {31'h0, sel}, {31'h0, tbl[i].exp_sel});
    end

    // 2. single frame 0xA5
    a5_bits = 8'hA5;
    step(1'b1, DADDR, 32'h0000_01A5, 1'b0);
    for (int k = 1; k <= 41; k++) begin
      step(1'b0, SADDR, 32'h0, 1'b0);
      if (k <= C) check("start_bit", {31'h0, uart_txd}, 32'h0);
      if ((k > C) && (k <= 9 * C) && (((k - 1) % C) == 0))
        check("data_bit", {31'h0, uart_txd}, {31'h0, a5_bits[(k - 1 - C) / C]});
      if (k == 20) check("mid_active", {31'h0, q_io[0]}, 32'h1);
      if (k == 40) check("busy_in_stop", {31'h0, busy}, 32'h1);
      if (k == 41) check("busy_fall", {31'h0, busy}, 32'h0);
    end
    idle(3);

    // 3. three back-to-back frames
    step(1'b1, DADDR, 32'h11, 1'b0);
    step(1'b1, DADDR, 32'h22, 1'b0);
    step(1'b1, DADDR, 32'h33, 1'b0);
    for (int k = 3; k <= 121; k++) begin
      step(1'b0, SADDR, 32'h0, 1'b0);
      if (k == 120) check("b2b_busy_end", {31'h0, busy}, 32'h1);
      if (k == 121) check("b2b_idle", {31'h0, busy}, 32'h0);
    end
    idle(3);

    // 4. overflow with 18 pushes, clear, drain
    for (int i = 0; i < 18; i++) step(1'b1, DADDR, 32'(8'h40 + i), 1'b0);
    check("ovf_status", {q_io[31:1], 1'b0}, 32'h0000_100C);
    step(1'b1, SADDR, 32'h0000_0008, 1'b0);
    check("ovf_clear", {31'h0, q_io[3]}, 32'h0);
    idle(17 * FRAME);
    check("drain_busy", {31'h0, busy}, 32'h0);

    // 5. reset mid-frame with 3 bytes queued
    for (int i = 0; i < 4; i++) step(1'b1, DADDR, 32'(8'hC0 + i), 1'b0);
    idle(11);
    step(1'b0, SADDR, 32'h0, 1'b1);
    check("rst_txd", {31'h0, uart_txd}, 32'h1);
    check("rst_status", q_io, 32'h0000_0002);
    idle(60);
    check("rst_no_frames", {31'h0, busy}, 32'h0);

    // 6. push while full on the STOP->START edge
    for (int i = 0; i < 17; i++) step(1'b1, DADDR, 32'(8'h80 + i), 1'b0);
    guard = 0;
    while (!(m_act && (m_t == FRAME - 1)) && (guard < 2 * FRAME)) begin
      step(1'b0, SADDR, 32'h0, 1'b0);
      guard++;
    end
    check("full_edge_found", {31'h0, (guard < 2 * FRAME)}, 32'h1);
    step(1'b1, DADDR, 32'h5A, 1'b0);
    check("full_push_count", {24'h0, q_io[15:8]}, 32'd16);
    check("full_push_ovf", {31'h0, q_io[3]}, 32'h0);
    step(1'b0, SADDR, 32'h0, 1'b1);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      case ($urandom_range(0, 3))
        0, 1:    a = DADDR;
        2:       a = SADDR;
        default: a = $urandom;
      endcase
      step(($urandom_range(0, 5) == 0), a, $urandom, ($urandom_range(0, 699) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
